// File: rtl/fifo_sr_arbiter.sv
// Write/read front-end scheduler for the shared multi-flux FIFO: independent
// round-robin arbitration per side, flux tagging on writes and routing of returned data.
module fifo_sr_arbiter #(
    parameter int  DATA_WIDTH = 8,
    parameter int  FLUX       = 2,
    parameter int  RD_LAT     = 1,
    localparam int TAG_WIDTH  = $clog2(FLUX)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FLUX-1:0]                 wr_req,
    input  logic [FLUX*DATA_WIDTH-1:0]      wr_data,
    output logic [FLUX-1:0]                 wr_ack,
    input  logic [FLUX-1:0]                 rd_req,
    output logic [FLUX-1:0]                 rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_data,
    input  logic                            fifo_full,
    input  logic [FLUX-1:0]                 fifo_empty,
    output logic                            fifo_write,
    output logic [DATA_WIDTH+TAG_WIDTH-1:0] fifo_din,
    output logic [FLUX-1:0]                 fifo_read,
    input  logic [DATA_WIDTH+TAG_WIDTH-1:0] fifo_dout
);

    // Returns {found, index} of the first set request scanning from ptr upward, wrapping.
    function automatic logic [TAG_WIDTH:0] rr_pick(input logic [FLUX-1:0] req,
                                                   input logic [TAG_WIDTH-1:0] ptr);
        logic [TAG_WIDTH:0]   res;
        logic [TAG_WIDTH-1:0] sel;
        int                   idx;
        res = {(TAG_WIDTH+1){1'b0}};
        for (int k = FLUX - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % FLUX;
            sel = TAG_WIDTH'(idx);
            if (req[sel]) begin
                res = {1'b1, sel};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [TAG_WIDTH-1:0] rr_next(input logic [TAG_WIDTH-1:0] g);
        if (g == TAG_WIDTH'(FLUX - 1)) begin
            return {TAG_WIDTH{1'b0}};
        end else begin
            return g + TAG_WIDTH'(1);
        end
    endfunction

    logic [TAG_WIDTH-1:0] wptr_r;
    logic [TAG_WIDTH-1:0] rptr_r;
    logic [TAG_WIDTH:0]   wr_pick_s;
    logic [TAG_WIDTH:0]   rd_pick_s;
    logic [TAG_WIDTH-1:0] wr_idx_s;
    logic [TAG_WIDTH-1:0] rd_idx_s;
    logic                 wr_go_s;
    logic                 rd_go_s;
    logic [FLUX-1:0]      rd_elig_s;
    logic [TAG_WIDTH-1:0] unused_tag_s;

    // Routing trusts the internally tracked grant, never the returned tag.
    assign unused_tag_s = fifo_dout[DATA_WIDTH +: TAG_WIDTH];

    // Grant selection for both sides; a full FIFO blocks writes only.
    always_comb begin
        rd_elig_s = rd_req & ~fifo_empty;
        wr_pick_s = rr_pick(wr_req, wptr_r);
        rd_pick_s = rr_pick(rd_elig_s, rptr_r);
        wr_idx_s  = wr_pick_s[TAG_WIDTH-1:0];
        rd_idx_s  = rd_pick_s[TAG_WIDTH-1:0];
        wr_go_s   = rst & ~fifo_full & wr_pick_s[TAG_WIDTH];
        rd_go_s   = rst & rd_pick_s[TAG_WIDTH];
    end

    // Round-robin pointers advance past the winner only when a grant fires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_r <= {TAG_WIDTH{1'b0}};
            rptr_r <= {TAG_WIDTH{1'b0}};
        end else begin
            wptr_r <= wr_go_s ? rr_next(wr_idx_s) : wptr_r;
            rptr_r <= rd_go_s ? rr_next(rd_idx_s) : rptr_r;
        end
    end

    // Write-side and read-strobe outputs.
    always_comb begin
        fifo_write = 1'b0;
        fifo_din   = {(DATA_WIDTH+TAG_WIDTH){1'b0}};
        wr_ack     = {FLUX{1'b0}};
        fifo_read  = {FLUX{1'b0}};
        if (wr_go_s) begin
            fifo_write = 1'b1;
            fifo_din   = {wr_idx_s, wr_data[wr_idx_s*DATA_WIDTH +: DATA_WIDTH]};
            wr_ack     = FLUX'(1) << wr_idx_s;
        end else begin
            fifo_write = 1'b0;
        end
        if (rd_go_s) begin
            fifo_read = FLUX'(1) << rd_idx_s;
        end else begin
            fifo_read = {FLUX{1'b0}};
        end
    end

    generate
        if (RD_LAT == 0) begin : g_lat0
            // Data returns in the strobe cycle, so route it with the live grant.
            always_comb begin
                rd_valid = {FLUX{1'b0}};
                rd_data  = {DATA_WIDTH{1'b0}};
                if (rd_go_s) begin
                    rd_valid = FLUX'(1) << rd_idx_s;
                    rd_data  = fifo_dout[DATA_WIDTH-1:0];
                end else begin
                    rd_data  = rst ? fifo_dout[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
                end
            end
        end else begin : g_lat1
            logic                 pending_v_r;
            logic [TAG_WIDTH-1:0] pending_id_r;

            // Remember which consumer owns the data arriving next cycle; reset drops it.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pending_v_r  <= 1'b0;
                    pending_id_r <= {TAG_WIDTH{1'b0}};
                end else begin
                    pending_v_r  <= rd_go_s;
                    pending_id_r <= rd_go_s ? rd_idx_s : pending_id_r;
                end
            end

            // Steer the returned payload to the remembered consumer.
            always_comb begin
                rd_valid = {FLUX{1'b0}};
                rd_data  = {DATA_WIDTH{1'b0}};
                if (rst) begin
                    rd_valid = pending_v_r ? (FLUX'(1) << pending_id_r) : {FLUX{1'b0}};
                    rd_data  = fifo_dout[DATA_WIDTH-1:0];
                end else begin
                    rd_valid = {FLUX{1'b0}};
                end
            end
        end
    endgenerate

endmodule
